spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
//  Parametrised SPI slave (mode 0/2) with an internal register file of NUM_REGS x DATA_W.
//  Frame format: slave-ID byte, address (ADDR_W bits), then one or more DATA_W-bit words.
//  All SPI inputs are oversampled in the system clock domain. Register contents are also
//  exported in parallel to downstream logic.
// PARAMETERS
//  DATA_W     8      register / data-word width in bits (4..32)
//  ADDR_W     8      SPI address field width in bits
//  NUM_REGS   4      number of registers (1..2**ADDR_W)
//  BASE_ADDR  8'h10  SPI address of register 0
//  ID_WR      8'hFF  slave-ID byte that opens a write frame
//  ID_RD      8'h00  slave-ID byte that opens a read frame
//  CPOL       0      SCLK idle level; sample on leading edge, shift on trailing edge (CPHA=0)
// PORTS
//  clock      in   1                 system clock; min 8x the SCLK frequency
//  reset      in   1                 asynchronous, active-high reset
//  ss         in   1                 chip select, active low, asynchronous input
//  sclk       in   1                 SPI clock, asynchronous input
//  mosi       in   1                 master-out data, MSB first
//  miso       out  1                 slave-out data, MSB first
//  miso_oe    out  1                 1 while a read frame is in RDATA; drives the pad tristate
//  busy       out  1                 1 whenever state != IDLE
//  wr_strobe  out  1                 1-cycle pulse on each committed register write
//  wr_index   out  $clog2(NUM_REGS)  index of the register written (valid with wr_strobe)
//  wr_data    out  DATA_W            value written (valid with wr_strobe)
//  regs_flat  out  NUM_REGS*DATA_W   register file; reg i occupies [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  - Reset: all outputs 0, all registers 0, state IDLE. Reset mid-frame aborts the frame;
//    no partial write is committed.
//  - ss, sclk and mosi pass through 2-FF synchronisers. Edges are detected on the synced
//    signals. mosi is sampled on the synced leading edge. miso updates on the cycle after
//    the synced trailing edge (3 clocks after the raw edge).
//  - FSM states: IDLE, ID, ADDR, WDATA, RDATA, IGNORE, DONE.
//    IDLE->ID on ss fall. After 8 sampled bits, ID goes to ADDR(wr) if ID==ID_WR,
//    to ADDR(rd) if ID==ID_RD, else to IGNORE.
//    ADDR->WDATA or RDATA after ADDR_W sampled bits.
//    ss rise in any non-IDLE state -> DONE; DONE -> IDLE after exactly 1 cycle.
//    A new ss fall while in DONE is missed; masters must hold ss high for >=4 clocks.
//  - Write: each DATA_W sampled bits in WDATA commit the word to register (addr-BASE_ADDR).
//    In the same cycle: wr_strobe=1, wr_index and wr_data valid, regs_flat updated.
//    Addresses outside BASE_ADDR..BASE_ADDR+NUM_REGS-1 are dropped: no strobe, no update.
//    A partial word at ss rise is discarded.
//  - Read: the register is latched into the shift register in the cycle the last address
//    bit is sampled. The MSB is driven after that bit's trailing edge; subsequent bits shift
//    on each trailing edge. Out-of-range reads return all zeros. miso=0 when miso_oe=0.
//  - Bit counters are $clog2(max(DATA_W,ADDR_W,8))+1 bits wide and clear on every state
//    change.
//  - IGNORE: no sampling, miso_oe=0, wait for ss rise.
//  - sclk edges while ss is high are ignored. An ss fall/rise in the same cycle as an sclk
//    edge: the ss event wins.
// CONFIGURATION
//  SPI_SLAVE_REGFILE_AUTOINC_EN
//   Defined: after each full data word (write or read) the address increments; from the
//     last register it wraps to BASE_ADDR. A read preloads the next register on the
//     sample edge of the last bit.
//   Undefined: the address is fixed for the frame. Repeated write words overwrite the same
//     register. Repeated read words resend the same value.
// STRUCTURE
//  spi_slave_pkg: state enum (3-bit), ID/BASE defaults, clog2 helper function.
//  Sub-module spi_sync_edge (2-FF sync plus rise/fall pulse) is instantiated for ss, sclk
//  and mosi (mosi uses only the synced level). The FSM, shift registers and register file
//  stay in this module.
// TESTING
//  1. Write frame ID=FF, addr=11, data=A5 -> one wr_strobe, wr_index=1, wr_data=A5;
//     regs_flat[15:8]=A5.
//  2. Read frame ID=00, addr=11 after test 1 -> miso shifts A5 MSB-first; miso_oe high
//     only in RDATA.
//  3. Bad ID=5A followed by 16 clocks -> no strobe, miso_oe=0; busy drops 1 cycle after
//     ss rise.
//  4. Write to addr=20 (out of range) -> no wr_strobe; read of addr=20 returns 00.
//  5. AUTOINC_EN: write addr=13, data 11,22 -> reg3=11, reg0=22 (wrap).
//     Without the macro -> reg3=22.
//  6. ss rise after 5 data bits, then reset asserted mid-ID on the next frame -> no write
//     committed; all outputs return to 0 immediately.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave register file.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StAddr,
    StWdata,
    StRdata,
    StIgnore,
    StDone
  } spi_state_e;

  localparam logic [7:0] DefIdWr     = 8'hFF;
  localparam logic [7:0] DefIdRd     = 8'h00;
  localparam logic [7:0] DefBaseAddr = 8'h10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave (CPHA=0) with an oversampled front end and a parallel-exported register file.
// Optional address auto-increment per data word: SPI_SLAVE_REGFILE_AUTOINC_EN.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DefBaseAddr),
  parameter logic [7:0]        ID_WR     = DefIdWr,
  parameter logic [7:0]        ID_RD     = DefIdRd,
  parameter bit                CPOL      = 1'b0,
  localparam int unsigned      IdxW      = (NUM_REGS > 1) ? clog2(NUM_REGS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ss,
  input  logic                         sclk,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  output logic                         busy,
  output logic                         wr_strobe,
  output logic [IdxW-1:0]              wr_index,
  output logic [DATA_W-1:0]            wr_data,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

  localparam int unsigned ShW  = max3(DATA_W, ADDR_W, 8);
  localparam int unsigned CntW = clog2(ShW) + 1;
  localparam int unsigned AW1  = ADDR_W + 1;
  localparam logic [ADDR_W:0] EndAddr = {1'b0, BASE_ADDR} + AW1'(NUM_REGS);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.ResetVal(1'b1)) u_sync_ss (
    .clock (clock),
    .reset (reset),
    .din   (ss),
    .dout  (ss_s),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.ResetVal(CPOL)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .din   (sclk),
    .dout  (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
    .clock (clock),
    .reset (reset),
    .din   (mosi),
    .dout  (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  spi_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ShW-1:0]      sh_q, sh_d, sh_in;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                rd_q, rd_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [IdxW-1:0]     wr_index_q, wr_index_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic lead, trail, sclk_act;
  logic unused_sync;

  assign lead     = CPOL ? sclk_fall : sclk_rise;
  assign trail    = CPOL ? sclk_rise : sclk_fall;
  assign sclk_act = ~ss_s;
  assign sh_in    = {sh_q[ShW-2:0], mosi_s};

  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall, sh_q[ShW-1]};

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < EndAddr);
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IdxW'(off);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    if (addr_hit(a) && (addr_idx(a) == IdxW'(NUM_REGS - 1))) begin
      return BASE_ADDR;
    end
    return a + ADDR_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    return addr_hit(a) ? regs_q[addr_idx(a)] : '0;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rd_d        = rd_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (state_q == StIdle) begin
      if (ss_fall) begin
        state_d = StId;
      end
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end else if (ss_rise) begin
      // Chip-select release wins over any coincident sclk edge.
      state_d = StDone;
    end else begin
      unique case (state_q)
        StId: begin
          if (lead && sclk_act) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(7)) begin
              if (sh_in[7:0] == ID_WR) begin
                state_d = StAddr;
                rd_d    = 1'b0;
              end else if (sh_in[7:0] == ID_RD) begin
                state_d = StAddr;
                rd_d    = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end
          end
        end
        StAddr: begin
          if (lead && sclk_act) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(ADDR_W - 1)) begin
              addr_d = sh_in[ADDR_W-1:0];
              if (rd_q) begin
                state_d = StRdata;
                tx_d    = read_word(sh_in[ADDR_W-1:0]);
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StWdata: begin
          if (lead && sclk_act) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(DATA_W - 1)) begin
              cnt_d = '0;
              if (addr_hit(addr_q)) begin
                regs_d[addr_idx(addr_q)] = sh_in[DATA_W-1:0];
                wr_strobe_d = 1'b1;
                wr_index_d  = addr_idx(addr_q);
                wr_data_d   = sh_in[DATA_W-1:0];
              end
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
              addr_d = addr_next(addr_q);
`endif
            end
          end
        end
        StRdata: begin
          if (lead && sclk_act) begin
            cnt_d = cnt_q + CntW'(1);
            // Reload on the last sample so the next trailing edge drives the new MSB.
            if (cnt_q == CntW'(DATA_W - 1)) begin
              cnt_d = '0;
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
              addr_d = addr_next(addr_q);
              tx_d   = read_word(addr_next(addr_q));
`else
              tx_d   = read_word(addr_q);
`endif
            end
          end else if (trail && sclk_act) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
    if (state_d != StRdata) begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rd_q        <= rd_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign miso_oe   = (state_q == StRdata);
  assign miso      = miso_q & miso_oe;
  assign busy      = (state_q != StIdle);
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: frame-level register model plus per-cycle compare.
module tb_spi_slave_regfile;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int NR   = 4;
  localparam int BASE = 16;
  localparam int HALF = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ss    = 1'b1;
  logic              sclk  = 1'b0;
  logic              mosi  = 1'b0;
  logic              miso, miso_oe, busy, wr_strobe;
  logic [1:0]        wr_index;
  logic [DW-1:0]     wr_data;
  logic [NR*DW-1:0]  regs_flat;

  spi_slave_regfile dut (
    .clock     (clock),
    .reset     (reset),
    .ss        (ss),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .regs_flat (regs_flat)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mregs [NR];
  wr_t        wq [$];
  wr_t        cur_w;
  logic [NR*DW-1:0] exp_flat;
  logic [7:0] wwords [4];
  logic [7:0] exp_rd [4];
  logic [7:0] got_rd [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [7:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + NR);
  endfunction

  function automatic logic [7:0] m_next(input logic [7:0] a);
    if (int'(a) == BASE + NR - 1) return 8'(BASE);
    return a + 8'd1;
  endfunction

  // Per-cycle compare against the model register file and expected write queue.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
      wq.delete();
    end else if (mon_en) begin
      if (wr_strobe) begin
        if (wq.size() == 0) begin
          check("unexpected_strobe", 64'(wr_strobe), 64'(0));
        end else begin
          cur_w = wq.pop_front();
          check("wr_index", 64'(wr_index), 64'(cur_w.idx));
          check("wr_data", 64'(wr_data), 64'(cur_w.data));
          mregs[cur_w.idx] = cur_w.data;
        end
      end
      for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = mregs[i];
      check("regs_flat", 64'(regs_flat), 64'(exp_flat));
      if (!miso_oe) check("miso_when_off", 64'(miso), 64'(0));
      if (!busy) check("oe_when_idle", 64'(miso_oe), 64'(0));
    end
  end

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    mosi = b;
    repeat (HALF) @(posedge clock);
    #1;
    r    = miso;
    oe   = miso_oe;
    sclk = 1'b1;
    repeat (HALF) @(posedge clock);
    #1;
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] addr, input int nwords,
                            input int extra_bits);
    logic [7:0] a;
    logic       r, oe;
    a = addr;
    for (int k = 0; k < nwords; k++) begin
      if (id == 8'hFF && m_hit(a)) wq.push_back('{idx: int'(a) - BASE, data: wwords[k]});
      exp_rd[k] = m_hit(a) ? mregs[int'(a) - BASE] : 8'h00;
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
      a = m_next(a);
`endif
    end
    @(posedge clock);
    #1 ss = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(id[i], r, oe);
      check("oe_in_id", 64'(oe), 64'(0));
    end
    if (id == 8'hFF || id == 8'h00) begin
      for (int i = AW - 1; i >= 0; i--) begin
        spi_bit(addr[i], r, oe);
        check("oe_in_addr", 64'(oe), 64'(0));
      end
    end
    for (int k = 0; k < nwords; k++) begin
      for (int i = DW - 1; i >= 0; i--) begin
        spi_bit((id == 8'hFF) ? wwords[k][i] : 1'b0, r, oe);
        got_rd[k][i] = r;
        if (id == 8'h00) begin
          check("miso_bit", 64'(r), 64'(exp_rd[k][i]));
          check("oe_in_rdata", 64'(oe), 64'(1));
        end else begin
          check("oe_not_read", 64'(oe), 64'(0));
        end
      end
    end
    for (int i = 0; i < extra_bits; i++) spi_bit(1'b1, r, oe);
    repeat (HALF) @(posedge clock);
    #1 ss = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("busy_in_done", 64'(busy), 64'(1));
    @(posedge clock);
    #1 check("busy_after_done", 64'(busy), 64'(0));
    check("writes_pending", 64'(wq.size()), 64'(0));
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, oe;
    repeat (3) @(posedge clock);
    #1;
    check("rst_regs", 64'(regs_flat), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_strobe", 64'(wr_strobe), 64'(0));
    check("rst_oe", 64'(miso_oe), 64'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // sclk activity with ss high must not start anything
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r, oe);
    check("idle_sclk_busy", 64'(busy), 64'(0));

    wwords[0] = 8'hA5;
    send_frame(8'hFF, 8'h11, 1, 0);
    check("t1_reg1", 64'(regs_flat[15:8]), 64'(8'hA5));

    send_frame(8'h00, 8'h11, 1, 0);
    check("t2_read", 64'(got_rd[0]), 64'(8'hA5));

    send_frame(8'h5A, 8'h00, 2, 0);
    check("t3_regs", 64'(regs_flat), 64'(32'h0000_A500));

    wwords[0] = 8'h77;
    send_frame(8'hFF, 8'h20, 1, 0);
    send_frame(8'h00, 8'h20, 1, 0);
    check("t4_read_oor", 64'(got_rd[0]), 64'(8'h00));
    check("t4_regs", 64'(regs_flat), 64'(32'h0000_A500));

    wwords[0] = 8'h11;
    wwords[1] = 8'h22;
    send_frame(8'hFF, 8'h13, 2, 0);
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
    check("t5_reg3", 64'(regs_flat[31:24]), 64'(8'h11));
    check("t5_reg0", 64'(regs_flat[7:0]), 64'(8'h22));
`else
    check("t5_reg3", 64'(regs_flat[31:24]), 64'(8'h22));
    check("t5_reg0", 64'(regs_flat[7:0]), 64'(8'h00));
`endif
    send_frame(8'h00, 8'h13, 2, 0);
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
    check("t5_rd0", 64'(got_rd[0]), 64'(8'h11));
    check("t5_rd1", 64'(got_rd[1]), 64'(8'h22));
`else
    check("t5_rd0", 64'(got_rd[0]), 64'(8'h22));
    check("t5_rd1", 64'(got_rd[1]), 64'(8'h22));
`endif

    // Partial word then ss rise: nothing may be committed
    send_frame(8'hFF, 8'h12, 0, 5);
    check("t6_reg2", 64'(regs_flat[23:16]), 64'(8'h00));

    @(posedge clock);
    #1 ss = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    spi_bit(1'b1, r, oe);
    spi_bit(1'b1, r, oe);
    spi_bit(1'b1, r, oe);
    spi_bit(1'b1, r, oe);
    check("t6_busy_mid_id", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("t6_rst_regs", 64'(regs_flat), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_oe", 64'(miso_oe), 64'(0));
    check("t6_rst_miso", 64'(miso), 64'(0));
    check("t6_rst_strobe", 64'(wr_strobe), 64'(0));
    check("t6_rst_index", 64'(wr_index), 64'(0));
    check("t6_rst_data", 64'(wr_data), 64'(0));
    ss   = 1'b1;
    sclk = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    wwords[0] = 8'h5C;
    send_frame(8'hFF, 8'h10, 1, 0);
    send_frame(8'h00, 8'h10, 1, 0);
    check("t7_read_after_reset", 64'(got_rd[0]), 64'(8'h5C));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
